vx_divergence_unit: RTL and testbench

//  Per-warp IPDOM divergence controller: successor to the single-port split/join block.

---
 rtl/vx_divergence_unit.sv | 200 ++++++++++++++++++++
 tb/tb_vx_divergence_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vx_divergence_unit.sv
// Per-warp IPDOM divergence stack: independent split/join channels, per-warp flush,
// full-stack backpressure, sticky error flags and an optional join output register.
module vx_divergence_unit #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int PC_BITS     = 30,
    parameter int DEPTH       = 8,
    parameter int OUT_REG     = 1,
    localparam int NW_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int PTR_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   split_valid,
    output logic                   split_ready,
    input  logic [NW_W-1:0]        split_wid,
    input  logic                   split_is_dvg,
    input  logic [NUM_THREADS-1:0] split_then_tmask,
    input  logic [NUM_THREADS-1:0] split_else_tmask,
    input  logic [PC_BITS-1:0]     split_next_pc,
    input  logic                   join_valid,
    input  logic [NW_W-1:0]        join_wid,
    input  logic [PTR_W-1:0]       join_stack_ptr,
    input  logic                   flush_valid,
    input  logic [NW_W-1:0]        flush_wid,
    output logic                   jout_valid,
    output logic [NW_W-1:0]        jout_wid,
    output logic                   jout_is_dvg,
    output logic                   jout_is_else,
    output logic [NUM_THREADS-1:0] jout_tmask,
    output logic [PC_BITS-1:0]     jout_pc,
    input  logic [NW_W-1:0]        query_wid,
    output logic [PTR_W-1:0]       query_ptr,
    output logic                   err_overflow,
    output logic                   err_mismatch
);

    localparam int EA_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                   vld_p0;
    logic                   dvg_p0;
    logic                   else_p0;
    logic [NUM_THREADS-1:0] tmask_p0;
    logic [PC_BITS-1:0]     pc_p0;
    logic [PTR_W-1:0]       join_ptr_cur;
    logic                   split_full;

    assign vld_p0 = join_valid;

    generate
        if (NUM_THREADS > 1) begin : g_stack
            logic [PTR_W-1:0]       wr_ptr     [NUM_WARPS];
            logic [DEPTH-1:0]       idx        [NUM_WARPS];
            logic [NUM_THREADS-1:0] reconv_mem [NUM_WARPS][DEPTH];
            logic [NUM_THREADS-1:0] else_mem   [NUM_WARPS][DEPTH];
            logic [PC_BITS-1:0]     pc_mem     [NUM_WARPS][DEPTH];
            logic [PTR_W-1:0]       split_ptr_cur;
            logic [EA_W-1:0]        push_ea;
            logic [EA_W-1:0]        top_ea;
            logic                   push;
            logic                   join_dvg;
            logic                   join_upd;
            logic                   top_idx;

            assign split_ptr_cur = wr_ptr[split_wid];
            assign join_ptr_cur  = wr_ptr[join_wid];
            assign query_ptr     = wr_ptr[query_wid];
            assign split_full    = (split_ptr_cur == PTR_W'(DEPTH));

            // Join and flush on the same warp win over a split.
            assign split_ready = !(split_is_dvg && split_full)
                              && !(join_valid && (join_wid == split_wid))
                              && !(flush_valid && (flush_wid == split_wid));

            assign push     = split_valid && split_ready && split_is_dvg;
            assign push_ea  = EA_W'(split_ptr_cur);
            assign top_ea   = EA_W'(join_ptr_cur - 1'b1);
            assign join_dvg = join_valid && (join_ptr_cur != '0)
                           && (join_stack_ptr == join_ptr_cur - 1'b1);
            assign top_idx  = idx[join_wid][top_ea];
            // A same-warp flush still lets the join read, but discards its stack update.
            assign join_upd = join_dvg && !(flush_valid && (flush_wid == join_wid));

            always_comb begin
                dvg_p0   = join_dvg;
                else_p0  = join_dvg && !top_idx;
                tmask_p0 = '0;
                pc_p0    = '0;
                if (join_dvg) begin
                    if (top_idx) begin
                        tmask_p0 = reconv_mem[join_wid][top_ea];
                    end else begin
                        tmask_p0 = else_mem[join_wid][top_ea];
                        pc_p0    = pc_mem[join_wid][top_ea];
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int w = 0; w < NUM_WARPS; w++) begin
                        wr_ptr[w] <= '0;
                        idx[w]    <= '0;
                    end
                end else begin
                    if (push) begin
                        wr_ptr[split_wid]      <= split_ptr_cur + 1'b1;
                        idx[split_wid][push_ea] <= 1'b0;
                    end
                    if (join_upd) begin
                        if (top_idx) begin
                            wr_ptr[join_wid] <= join_ptr_cur - 1'b1;
                        end else begin
                            idx[join_wid][top_ea] <= 1'b1;
                        end
                    end
                    if (flush_valid) begin
                        wr_ptr[flush_wid] <= '0;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (push) begin
                    reconv_mem[split_wid][push_ea] <= split_then_tmask | split_else_tmask;
                    else_mem[split_wid][push_ea]   <= split_else_tmask;
                    pc_mem[split_wid][push_ea]     <= split_next_pc;
                end
            end
        end else begin : g_nostack
            assign split_ready  = 1'b1;
            assign query_ptr    = '0;
            assign join_ptr_cur = '0;
            assign split_full   = 1'b0;
            assign dvg_p0       = 1'b0;
            assign else_p0      = 1'b0;
            assign tmask_p0     = '1;
            assign pc_p0        = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_overflow <= 1'b0;
            err_mismatch <= 1'b0;
        end else begin
            if (split_valid && split_is_dvg && split_full) begin
                err_overflow <= 1'b1;
            end
            if (join_valid && (join_stack_ptr > join_ptr_cur)) begin
                err_mismatch <= 1'b1;
            end
        end
    end

    // Stage p0 -> p1: optional join result register.
    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                   vld_p1;
            logic [NW_W-1:0]        wid_p1;
            logic                   dvg_p1;
            logic                   else_p1;
            logic [NUM_THREADS-1:0] tmask_p1;
            logic [PC_BITS-1:0]     pc_p1;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_p1   <= 1'b0;
                    wid_p1   <= '0;
                    dvg_p1   <= 1'b0;
                    else_p1  <= 1'b0;
                    tmask_p1 <= '0;
                    pc_p1    <= '0;
                end else begin
                    vld_p1   <= vld_p0;
                    wid_p1   <= join_wid;
                    dvg_p1   <= dvg_p0;
                    else_p1  <= else_p0;
                    tmask_p1 <= tmask_p0;
                    pc_p1    <= pc_p0;
                end
            end

            assign jout_valid   = vld_p1;
            assign jout_wid     = wid_p1;
            assign jout_is_dvg  = dvg_p1;
            assign jout_is_else = else_p1;
            assign jout_tmask   = tmask_p1;
            assign jout_pc      = pc_p1;
        end else begin : g_ocomb
            assign jout_valid   = vld_p0;
            assign jout_wid     = join_wid;
            assign jout_is_dvg  = dvg_p0;
            assign jout_is_else = else_p0;
            assign jout_tmask   = tmask_p0;
            assign jout_pc      = pc_p0;
        end
    endgenerate

endmodule

// File: tb/tb_vx_divergence_unit.sv
// Directed bench for vx_divergence_unit (4 warps, 4 threads, depth 8, registered output).
module tb_vx_divergence_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        split_valid = 1'b0;
    logic        split_ready;
    logic [1:0]  split_wid = '0;
    logic        split_is_dvg = 1'b0;
    logic [3:0]  split_then_tmask = '0;
    logic [3:0]  split_else_tmask = '0;
    logic [29:0] split_next_pc = '0;
    logic        join_valid = 1'b0;
    logic [1:0]  join_wid = '0;
    logic [3:0]  join_stack_ptr = '0;
    logic        flush_valid = 1'b0;
    logic [1:0]  flush_wid = '0;
    logic        jout_valid;
    logic [1:0]  jout_wid;
    logic        jout_is_dvg;
    logic        jout_is_else;
    logic [3:0]  jout_tmask;
    logic [29:0] jout_pc;
    logic [1:0]  query_wid = '0;
    logic [3:0]  query_ptr;
    logic        err_overflow;
    logic        err_mismatch;

    int n_checks = 0;
    int n_err    = 0;

    vx_divergence_unit #(
        .NUM_WARPS(4), .NUM_THREADS(4), .PC_BITS(30), .DEPTH(8), .OUT_REG(1)
    ) dut (
        .clk(clk), .reset(reset),
        .split_valid(split_valid), .split_ready(split_ready), .split_wid(split_wid),
        .split_is_dvg(split_is_dvg), .split_then_tmask(split_then_tmask),
        .split_else_tmask(split_else_tmask), .split_next_pc(split_next_pc),
        .join_valid(join_valid), .join_wid(join_wid), .join_stack_ptr(join_stack_ptr),
        .flush_valid(flush_valid), .flush_wid(flush_wid),
        .jout_valid(jout_valid), .jout_wid(jout_wid), .jout_is_dvg(jout_is_dvg),
        .jout_is_else(jout_is_else), .jout_tmask(jout_tmask), .jout_pc(jout_pc),
        .query_wid(query_wid), .query_ptr(query_ptr),
        .err_overflow(err_overflow), .err_mismatch(err_mismatch)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic        sv;
        logic [1:0]  sw;
        logic        sd;
        logic [3:0]  st;
        logic [3:0]  se;
        logic [29:0] spc;
        logic        jv;
        logic [1:0]  jw;
        logic [3:0]  jp;
        logic        fv;
        logic [1:0]  fw;
        logic [1:0]  qw;
        logic        e_rdy;
        logic        e_jv;
        logic        e_dvg;
        logic        e_else;
        logic [3:0]  e_tm;
        logic [29:0] e_pc;
        logic [3:0]  e_q;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check split_ready before the edge, results after it.
    task automatic apply(input vec_t v, input int id);
        @(negedge clk);
        split_valid      = v.sv;
        split_wid        = v.sw;
        split_is_dvg     = v.sd;
        split_then_tmask = v.st;
        split_else_tmask = v.se;
        split_next_pc    = v.spc;
        join_valid       = v.jv;
        join_wid         = v.jw;
        join_stack_ptr   = v.jp;
        flush_valid      = v.fv;
        flush_wid        = v.fw;
        query_wid        = v.qw;
        #1;
        if (v.sv) check($sformatf("v%0d split_ready", id), 32'(split_ready), 32'(v.e_rdy));
        @(posedge clk);
        #1;
        check($sformatf("v%0d jout_valid", id), 32'(jout_valid), 32'(v.e_jv));
        if (v.e_jv) begin
            check($sformatf("v%0d jout_wid", id), 32'(jout_wid), 32'(v.jw));
            check($sformatf("v%0d jout_is_dvg", id), 32'(jout_is_dvg), 32'(v.e_dvg));
            check($sformatf("v%0d jout_is_else", id), 32'(jout_is_else), 32'(v.e_else));
            check($sformatf("v%0d jout_tmask", id), 32'(jout_tmask), 32'(v.e_tm));
            check($sformatf("v%0d jout_pc", id), 32'(jout_pc), 32'(v.e_pc));
        end
        check($sformatf("v%0d query_ptr", id), 32'(query_ptr), 32'(v.e_q));
    endtask

    vec_t vecs [15];
    vec_t v;

    initial begin
        //           sv    sw    sd    st       se       spc       jv    jw    jp    fv    fw    qw    rdy   ejv   edvg  eelse etm      epc       eq
        vecs[0]  = '{1'b1, 2'd1, 1'b1, 4'b0011, 4'b1100, 30'h40,  1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 30'h0,   4'd1};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 30'h0,   1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 30'h0,   4'd0};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 30'h0,   1'b1, 2'd1, 4'd0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1100, 30'h40,  4'd1};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 30'h0,   1'b1, 2'd1, 4'd0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 30'h0,   4'd0};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 30'h0,   1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 30'h0,   4'd0};
        vecs[5]  = '{1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 30'h0,   1'b1, 2'd0, 4'd3, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 30'h0,   4'd0};
        vecs[6]  = '{1'b1, 2'd1, 1'b1, 4'b0001, 4'b0010, 30'h100, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 30'h0,   4'd1};
        vecs[7]  = '{1'b1, 2'd1, 1'b1, 4'b0100, 4'b1000, 30'h200, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 30'h0,   4'd2};
        vecs[8]  = '{1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 30'h0,   1'b1, 2'd1, 4'd0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 30'h0,   4'd2};
        vecs[9]  = '{1'b1, 2'd3, 1'b1, 4'b1000, 4'b0111, 30'h300, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 30'h0,   4'd1};
        vecs[10] = '{1'b1, 2'd3, 1'b1, 4'b0001, 4'b0110, 30'h3F0, 1'b1, 2'd3, 4'd0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0111, 30'h300, 4'd1};
        vecs[11] = '{1'b1, 2'd0, 1'b1, 4'b0101, 4'b1010, 30'h500, 1'b1, 2'd3, 4'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 30'h0,   4'd1};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 30'h0,   1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 30'h0,   4'd0};
        vecs[13] = '{1'b1, 2'd2, 1'b0, 4'b1111, 4'b0000, 30'h77,  1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 30'h0,   4'd0};
        vecs[14] = '{1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 30'h0,   1'b1, 2'd1, 4'd1, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, 30'h200, 4'd2};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset jout_valid", 32'(jout_valid), 32'd0);
        check("reset err_overflow", 32'(err_overflow), 32'd0);
        check("reset err_mismatch", 32'(err_mismatch), 32'd0);
        for (int w = 0; w < 4; w++) begin
            query_wid = 2'(w);
            #1;
            check($sformatf("reset query_ptr w%0d", w), 32'(query_ptr), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) apply(vecs[i], i);
        check("table err_mismatch", 32'(err_mismatch), 32'd1);
        check("table err_overflow", 32'(err_overflow), 32'd0);

        // Flush w1 at depth 3 together with a join on w1
        v = '0; v.sv = 1'b1; v.sw = 2'd1; v.sd = 1'b1; v.st = 4'b0011; v.se = 4'b0100;
        v.spc = 30'h600; v.qw = 2'd1; v.e_rdy = 1'b1; v.e_q = 4'd3;
        apply(v, 20);
        v = '0; v.jv = 1'b1; v.jw = 2'd1; v.jp = 4'd2; v.fv = 1'b1; v.fw = 2'd1; v.qw = 2'd1;
        v.e_jv = 1'b1; v.e_dvg = 1'b1; v.e_else = 1'b1; v.e_tm = 4'b0100; v.e_pc = 30'h600; v.e_q = 4'd0;
        apply(v, 21);
        v = '0; v.qw = 2'd1; v.e_q = 4'd0;
        apply(v, 22);

        // Fill w2 to full depth, then one more split
        for (int k = 0; k < 8; k++) begin
            v = '0; v.sv = 1'b1; v.sw = 2'd2; v.sd = 1'b1; v.st = 4'(k + 1); v.se = 4'(k * 5 + 3);
            v.spc = 30'(32'h1000 + k); v.qw = 2'd2; v.e_rdy = 1'b1; v.e_q = 4'(k + 1);
            apply(v, 100 + k);
        end
        check("pre-overflow err_overflow", 32'(err_overflow), 32'd0);
        v = '0; v.sv = 1'b1; v.sw = 2'd2; v.sd = 1'b1; v.st = 4'b1111; v.se = 4'b1111;
        v.spc = 30'h3FF; v.qw = 2'd2; v.e_rdy = 1'b0; v.e_q = 4'd8;
        apply(v, 108);
        check("overflow err_overflow", 32'(err_overflow), 32'd1);

        // Nested unwind of w2: else path then reconvergence per level
        for (int p = 7; p >= 0; p--) begin
            v = '0; v.jv = 1'b1; v.jw = 2'd2; v.jp = 4'(p); v.qw = 2'd2;
            v.e_jv = 1'b1; v.e_dvg = 1'b1; v.e_else = 1'b1;
            v.e_tm = 4'(p * 5 + 3); v.e_pc = 30'(32'h1000 + p); v.e_q = 4'(p + 1);
            apply(v, 200 + 2 * p);
            v.e_else = 1'b0; v.e_tm = 4'(p + 1) | 4'(p * 5 + 3); v.e_pc = '0; v.e_q = 4'(p);
            apply(v, 201 + 2 * p);
        end

        // Asynchronous reset while a join result is being presented
        @(negedge clk);
        split_valid = 1'b0; join_valid = 1'b1; join_wid = 2'd0; join_stack_ptr = 4'd0;
        @(posedge clk);
        #1;
        check("prereset jout_valid", 32'(jout_valid), 32'd1);
        check("prereset jout_tmask", 32'(jout_tmask), 32'b1010);
        reset = 1'b1;
        #1;
        check("async reset jout_valid", 32'(jout_valid), 32'd0);
        check("async reset err_overflow", 32'(err_overflow), 32'd0);
        check("async reset err_mismatch", 32'(err_mismatch), 32'd0);
        for (int w = 0; w < 4; w++) begin
            query_wid = 2'(w);
            #1;
            check($sformatf("async reset query_ptr w%0d", w), 32'(query_ptr), 32'd0);
        end
        @(negedge clk);
        join_valid = 1'b0;
        reset = 1'b0;
        v = '0; v.sv = 1'b1; v.sw = 2'd0; v.sd = 1'b1; v.st = 4'b0001; v.se = 4'b1110;
        v.spc = 30'h80; v.qw = 2'd0; v.e_rdy = 1'b1; v.e_q = 4'd1;
        apply(v, 300);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
